seg_scan_disp: RTL and testbench



---
 rtl/seg_pkg.sv | 33 +++
 rtl/seg_bin2bcd.sv | 62 ++++++
 rtl/seg_scan_disp.sv | 170 +++++++++++++++++
 tb/tb_seg_scan_disp.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: segment codes, buffer symbol encoding and FSM state type for seg_scan_disp
package seg_pkg;

    localparam logic [3:0] SYM_BLANK = 4'd10;
    localparam logic [3:0] SYM_MINUS = 4'd11;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FORMAT = 2'd2
    } state_t;

    function automatic logic [6:0] sym2seg(input logic [3:0] s);
        case (s)
            4'd0:      return 7'h40;
            4'd1:      return 7'h79;
            4'd2:      return 7'h24;
            4'd3:      return 7'h30;
            4'd4:      return 7'h19;
            4'd5:      return 7'h12;
            4'd6:      return 7'h02;
            4'd7:      return 7'h78;
            4'd8:      return 7'h00;
            4'd9:      return 7'h10;
            SYM_MINUS: return SEG_MINUS;
            default:   return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg_bin2bcd.sv
// seg_bin2bcd: sequential double-dabble converter, one bit per cycle after start
module seg_bin2bcd #(
    parameter int DATA_W = 20,
    parameter int BCD_N  = DATA_W / 3 + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATA_W-1:0]    bin,
    output logic                 busy,
    output logic                 done,
    output logic [BCD_N*4-1:0]   bcd
);

    localparam int CW = $clog2(DATA_W + 1);

    logic [DATA_W-1:0]  bin_q, bin_d;
    logic [BCD_N*4-1:0] bcd_q, bcd_d, adj;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               run_q, run_d;

    assign busy = run_q;
    assign done = run_q && cnt_q == CW'(DATA_W - 1);
    assign bcd  = bcd_q;

    // load on start, then per step: add 3 to every nibble >= 5 and shift {bcd,bin} left
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < BCD_N; i++)
            adj[4*i+:4] = bcd_q[4*i+:4] >= 4'd5 ? bcd_q[4*i+:4] + 4'd3 : bcd_q[4*i+:4];
        bin_d = bin_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        run_d = run_q;
        if (start && !run_q) begin
            bin_d = bin;
            bcd_d = '0;
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            {bcd_d, bin_d} = {adj, bin_q} << 1;
            cnt_d = cnt_q + 1'b1;
            run_d = !done;
        end
    end

    // converter state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/seg_scan_disp.sv
// seg_scan_disp: multiplexed 7-segment controller with BCD conversion and formatting; SEG_BLINK_EN adds per-digit blink
module seg_scan_disp
    import seg_pkg::*;
#(
    parameter int DIGITS      = 6,
    parameter int DATA_W      = 20,
    parameter int SCAN_DIV    = 50000,
    parameter int SEL_ACT_LOW = 1,
    parameter int SEG_ACT_LOW = 1
`ifdef SEG_BLINK_EN
    ,
    parameter int BLINK_DIV   = 250
`endif
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [DATA_W-1:0] data,
    input  logic [DIGITS-1:0] point,
    input  logic              sign,
    input  logic              load,
    input  logic              en,
`ifdef SEG_BLINK_EN
    input  logic [DIGITS-1:0] blink,
`endif
    output logic              busy,
    output logic              ovf,
    output logic [DIGITS-1:0] seg_sel,
    output logic [7:0]        seg_led
);

    localparam int BCD_N = DATA_W / 3 + 1;
    localparam int NX    = DIGITS > BCD_N ? DIGITS : BCD_N;
    localparam int IW    = $clog2(DIGITS);
    localparam int PW    = $clog2(SCAN_DIV);

    state_t                  state_q, state_d;
    logic [DIGITS-1:0]       point_q, point_d;
    logic                    sign_q, sign_d;
    logic [DIGITS-1:0][3:0]  sym_q, sym_d, fmt_sym;
    logic [DIGITS-1:0]       dp_q, dp_d, fmt_dp;
    logic                    ovf_q, ovf_d, fmt_ovf, hi_ovf;
    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [DIGITS-1:0]       sel_q, sel_d;
    logic [7:0]              led_q, led_d;
    logic                    start, eng_busy, eng_done, tc, blank_dig;
    logic [BCD_N*4-1:0]      bcd;
    logic [NX*4-1:0]         bcd_x;
    int                      fmt_h;

    assign start   = load && state_q == ST_IDLE && !eng_busy;
    assign busy    = state_q != ST_IDLE;
    assign ovf     = ovf_q;
    assign seg_sel = sel_q;
    assign seg_led = led_q;
    assign bcd_x   = (NX*4)'(bcd);
    assign tc      = presc_q == PW'(SCAN_DIV - 1);

    seg_bin2bcd #(
        .DATA_W (DATA_W),
        .BCD_N  (BCD_N)
    ) u_b2b (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .start (start),
        .bin   (data),
        .busy  (eng_busy),
        .done  (eng_done),
        .bcd   (bcd)
    );

    // conversion sequencing and capture of point/sign alongside data
    always_comb begin
        state_d = state_q == ST_IDLE  ? (start ? ST_SHIFT : ST_IDLE) :
                  state_q == ST_SHIFT ? (eng_done ? ST_FORMAT : ST_SHIFT) : ST_IDLE;
        point_d = start ? point : point_q;
        sign_d  = start ? sign : sign_q;
    end

    // display formatting: extent, sign placement, dp and overflow from the finished BCD
    always_comb begin
        hi_ovf = 1'b0;
        for (int i = DIGITS; i < BCD_N; i++)
            hi_ovf = hi_ovf | (bcd_x[4*i+:4] != 4'd0);
        fmt_h = 0;
        for (int i = 0; i < DIGITS; i++)
            if (bcd_x[4*i+:4] != 4'd0 || point_q[i])
                fmt_h = i;
        fmt_ovf = hi_ovf || (sign_q && fmt_h == DIGITS - 1);
        for (int i = 0; i < DIGITS; i++) begin
            fmt_sym[i] = fmt_ovf ? SYM_MINUS :
                         i <= fmt_h ? bcd_x[4*i+:4] :
                         (sign_q && i == fmt_h + 1) ? SYM_MINUS : SYM_BLANK;
            fmt_dp[i]  = !fmt_ovf && i <= fmt_h && point_q[i];
        end
        sym_d = state_q == ST_FORMAT ? fmt_sym : sym_q;
        dp_d  = state_q == ST_FORMAT ? fmt_dp : dp_q;
        ovf_d = state_q == ST_FORMAT ? fmt_ovf : ovf_q;
    end

    // free-running prescaler and digit index, independent of en and busy
    always_comb begin
        presc_d = tc ? '0 : presc_q + 1'b1;
        idx_d   = tc ? (idx_q == IW'(DIGITS - 1) ? '0 : idx_q + 1'b1) : idx_q;
    end

`ifdef SEG_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV + 1);

    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d, bwrap;

    assign bwrap = tc && bcnt_q == BW'(BLINK_DIV - 1);

    // blink half-period counter in scan slots; phase 1 is the off-phase
    always_comb begin
        bcnt_d    = bwrap ? '0 : tc ? bcnt_q + 1'b1 : bcnt_q;
        phase_d   = bwrap ? !phase_q : phase_q;
        blank_dig = phase_q && blink[idx_q];
    end

    // blink state registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            bcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
        end
    end
`else
    assign blank_dig = 1'b0;
`endif

    // registered pin drive: one-hot select and encoded segments, then polarity
    always_comb begin
        sel_d = (en ? DIGITS'(1) << idx_q : '0) ^ {DIGITS{SEL_ACT_LOW != 0}};
        led_d = (en && !blank_dig ? {~dp_q[idx_q], sym2seg(sym_q[idx_q])} : 8'hFF)
                ^ {8{SEG_ACT_LOW == 0}};
    end

    // all controller state registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            point_q <= '0;
            sign_q  <= 1'b0;
            sym_q   <= {DIGITS{SYM_BLANK}};
            dp_q    <= '0;
            ovf_q   <= 1'b0;
            presc_q <= '0;
            idx_q   <= '0;
            sel_q   <= {DIGITS{SEL_ACT_LOW != 0}};
            led_q   <= {8{SEG_ACT_LOW != 0}};
        end else begin
            state_q <= state_d;
            point_q <= point_d;
            sign_q  <= sign_d;
            sym_q   <= sym_d;
            dp_q    <= dp_d;
            ovf_q   <= ovf_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            led_q   <= led_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_disp.sv
// tb_seg_scan_disp: directed bench for seg_scan_disp (6 digits, 20-bit data, SCAN_DIV=4, active-low)
module tb_seg_scan_disp;

    logic        clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [19:0] data = '0;
    logic [5:0]  point = '0;
    logic        sign = 1'b0;
    logic        load = 1'b0;
    logic        en = 1'b1;
    logic        busy, ovf;
    logic [5:0]  seg_sel;
    logic [7:0]  seg_led;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    seg_scan_disp #(
        .DIGITS      (6),
        .DATA_W      (20),
        .SCAN_DIV    (4),
        .SEL_ACT_LOW (1),
        .SEG_ACT_LOW (1)
    ) dut (
        .sys_clk (clk),
        .sys_rst (sys_rst),
        .data    (data),
        .point   (point),
        .sign    (sign),
        .load    (load),
        .en      (en),
`ifdef SEG_BLINK_EN
        .blink   (6'b0),
`endif
        .busy    (busy),
        .ovf     (ovf),
        .seg_sel (seg_sel),
        .seg_led (seg_led)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n == 100) chk("idle_timeout", busy, 0);
        @(negedge clk);
    endtask

    task automatic ld(input logic [19:0] d, input logic s, input logic [5:0] p);
        @(negedge clk);
        data = d; sign = s; point = p; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_idle();
    endtask

    // exp packs expected seg_led for digits 5..0, digit 0 in the low byte
    task automatic show(input string tag, input logic [47:0] exp);
        logic [5:0] want;
        int n;
        for (int i = 0; i < 6; i++) begin
            want = ~(6'd1 << i);
            n = 0;
            while (seg_sel !== want && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("%s_sel%0d", tag, i), seg_sel, want);
            chk($sformatf("%s_led%0d", tag, i), seg_led, exp[8*i+:8]);
        end
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_sel", seg_sel, 6'h3F);
        chk("rst_led", seg_led, 8'hFF);
        sys_rst = 1'b0;

        ld(20'd1234, 1'b0, 6'b000000);
        chk("b1234_ovf", ovf, 0);
        show("b1234", 48'hFFFF_F9A4_B099);

        ld(20'd42, 1'b1, 6'b000100);
        chk("s42_ovf", ovf, 0);
        show("s42", 48'hFFFF_BF40_99A4);

        ld(20'd999999, 1'b0, 6'b000000);
        chk("max_ovf", ovf, 0);
        show("max", 48'h9090_9090_9090);

        ld(20'd1000000, 1'b0, 6'b000000);
        chk("big_ovf", ovf, 1);
        show("big", 48'hBFBF_BFBF_BFBF);

        ld(20'd123456, 1'b1, 6'b000000);
        chk("sgnfull_ovf", ovf, 1);
        show("sgnfull", 48'hBFBF_BFBF_BFBF);

        @(negedge clk);
        data = 20'd777; sign = 1'b0; point = '0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (9) @(negedge clk);
        sys_rst = 1'b1; load = 1'b1;
        @(negedge clk);
        sys_rst = 1'b0; load = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_ovf", ovf, 0);
        chk("midrst_led", seg_led, 8'hFF);
        chk("midrst_sel", seg_sel, 6'h3F);
        @(negedge clk);
        chk("midrst_load_ign", busy, 0);
        show("midrst", 48'hFFFF_FFFF_FFFF);

        @(negedge clk);
        data = 20'd111; load = 1'b1;
        n = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (busy) n++;
            load = (c == 4);
            if (c == 4) data = 20'd222;
        end
        chk("hs_busy_cycles", n, 21);
        show("hs_first", 48'hFFFF_FFF9_F9F9);

        @(negedge clk);
        data = 20'd555; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        data = 20'd333; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("b2b_busy", busy, 1);
        wait_idle();
        show("b2b", 48'hFFFF_FFB0_B0B0);

        n = 0;
        while (seg_sel === 6'h3E && n < 40) begin
            @(negedge clk);
            n++;
        end
        while (seg_sel !== 6'h3E && n < 80) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("scan_hold", seg_sel, 6'h3E);
        @(negedge clk);
        chk("scan_1", seg_sel, 6'h3D);
        repeat (4) @(negedge clk);
        chk("scan_2", seg_sel, 6'h3B);
        repeat (4) @(negedge clk);
        chk("scan_3", seg_sel, 6'h37);
        repeat (4) @(negedge clk);
        chk("scan_4", seg_sel, 6'h2F);
        repeat (4) @(negedge clk);
        chk("scan_5", seg_sel, 6'h1F);
        repeat (4) @(negedge clk);
        chk("scan_wrap", seg_sel, 6'h3E);

        en = 1'b0;
        @(negedge clk);
        chk("dis_sel", seg_sel, 6'h3F);
        chk("dis_led", seg_led, 8'hFF);
        repeat (10) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        chk("reen_sel", seg_sel, 6'h37);
        chk("reen_led", seg_led, 8'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
